// File: rtl/keyboard.sv
// keyboard: buffers key codes from an external producer in a circular FIFO
// and exposes them to a CPU through a two-register read port.
//
// Ports
//   clock      : single clock; all state changes on its falling edge
//   reset      : asynchronous, active-low reset
//   key_strobe : producer offers key_data on this edge (no backpressure)
//   key_data   : 8-bit character code from the producer
//   read       : CPU read strobe
//   address    : 0 = DATA register, 1 = STATUS register
//   data_out   : selected register value, combinational from pre-edge state
//   irq        : character available (FIFO not empty), combinational
module keyboard #(
   parameter int unsigned DEPTH = 16
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       key_strobe,
   input  logic [7:0] key_data,
   input  logic       read,
   input  logic       address,
   output logic [7:0] data_out,
   output logic       irq
);

   localparam int unsigned AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = AW + 1;

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [CW-1:0] count;
   logic          overflow;

   logic empty;
   logic full;
   logic pop;
   logic push;
   logic ovf_set;
   logic ovf_clr;

   // FIFO control decode
   always_comb begin
      empty   = (count == '0);
      full    = (count == CW'(DEPTH));
      pop     = read && !address && !empty;
      // a pop on the same edge frees the slot a full FIFO needs
      push    = key_strobe && (!full || pop);
      ovf_set = key_strobe && full && !pop;
      ovf_clr = read && address;
   end

   // Pointer, count and sticky overflow state
   always_ff @(negedge clock or negedge reset) begin
      if (!reset) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
         // a new overflow wins over a same-edge status-read clear
         if (ovf_set)      overflow <= 1'b1;
         else if (ovf_clr) overflow <= 1'b0;
      end
   end

   // Character storage; contents are don't-care after reset
   always_ff @(negedge clock) begin
      if (push && reset) mem[wr_ptr] <= key_data;
   end

   // Register read mux and interrupt
   always_comb begin
      data_out = 8'h00;
      if (address)
         data_out = {5'b0, overflow, full, !empty};
      else if (!empty)
         data_out = mem[rd_ptr];
      irq = !empty;
   end

endmodule

// File: tb/tb_keyboard.sv
// tb_keyboard: scoreboard bench for keyboard. A queue model of the FIFO and
// overflow flag supplies every expected register value and irq level.
module tb_keyboard;

   localparam int unsigned DEPTH = 16;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       key_strobe = 1'b0;
   logic [7:0] key_data = 8'h00;
   logic       read = 1'b0;
   logic       address = 1'b0;
   logic [7:0] data_out;
   logic       irq;

   int checks = 0;
   int failures = 0;

   logic [7:0] sb_q[$];
   bit         sb_ovf = 1'b0;
   logic [7:0] d;

   keyboard #(.DEPTH(DEPTH)) dut (
      .clock      (clock),
      .reset      (reset),
      .key_strobe (key_strobe),
      .key_data   (key_data),
      .read       (read),
      .address    (address),
      .data_out   (data_out),
      .irq        (irq)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %02h expected %02h", tag, got, exp);
      end
   endtask

   // One bus cycle: drive after rising edge, compare before the falling
   // (active) edge, then advance the scoreboard model.
   task automatic cycle(input string tag, input bit s, input logic [7:0] kd,
                        input bit rd, input bit a, output logic [7:0] dv);
      logic [7:0] exp;
      bit m_empty, m_full, m_pop, m_push;
      @(posedge clock);
      key_strobe = s; key_data = kd; read = rd; address = a;
      #1;
      m_empty = (sb_q.size() == 0);
      m_full  = (sb_q.size() == DEPTH);
      if (a)            exp = {5'b0, sb_ovf, m_full, !m_empty};
      else if (m_empty) exp = 8'h00;
      else              exp = sb_q[0];
      check(tag, data_out, exp);
      check({tag, "_irq"}, {7'b0, irq}, {7'b0, !m_empty});
      dv = data_out;
      m_pop  = rd && !a && !m_empty;
      m_push = s && (!m_full || m_pop);
      if (m_pop)  void'(sb_q.pop_front());
      if (m_push) sb_q.push_back(kd);
      if (rd && a) sb_ovf = 1'b0;
      if (s && !m_push) sb_ovf = 1'b1;
      @(negedge clock);
      #1;
      key_strobe = 1'b0; read = 1'b0; address = 1'b0;
   endtask

   initial begin
      // reset state
      #3;
      check("rst_irq", {7'b0, irq}, 8'h00);
      check("rst_data", data_out, 8'h00);
      address = 1'b1; #1;
      check("rst_status", data_out, 8'h00);
      address = 1'b0;
      @(posedge clock); #1 reset = 1'b1;

      // basic order
      cycle("b_push", 1, 8'h41, 0, 0, d);
      cycle("b_push", 1, 8'h42, 0, 0, d);
      cycle("b_push", 1, 8'h43, 0, 0, d);
      cycle("b_stat", 0, 8'h00, 0, 1, d);
      check("b_stat_const", d, 8'h01);
      for (int i = 0; i < 3; i++) begin
         cycle("b_read", 0, 8'h00, 1, 0, d);
         check("b_read_const", d, 8'h41 + 8'(i));
      end
      cycle("b_stat_end", 0, 8'h00, 0, 1, d);
      check("b_stat_end_const", d, 8'h00);

      // fill and overflow
      for (int i = 0; i < 16; i++) cycle("f_push", 1, 8'(i), 0, 0, d);
      cycle("f_ovf", 1, 8'h55, 0, 0, d);
      cycle("f_stat1", 0, 8'h00, 1, 1, d);
      check("f_stat1_const", d, 8'h07);
      cycle("f_stat2", 0, 8'h00, 1, 1, d);
      check("f_stat2_const", d, 8'h03);
      for (int i = 0; i < 16; i++) begin
         cycle("f_read", 0, 8'h00, 1, 0, d);
         check("f_read_const", d, 8'(i));
      end

      // push and pop together while full
      for (int i = 0; i < 16; i++) cycle("pp_fill", 1, 8'(i), 0, 0, d);
      cycle("pp_both", 1, 8'h99, 1, 0, d);
      check("pp_both_const", d, 8'h00);
      cycle("pp_stat", 0, 8'h00, 0, 1, d);
      check("pp_stat_const", d, 8'h03);
      for (int i = 0; i < 16; i++) cycle("pp_read", 0, 8'h00, 1, 0, d);
      check("pp_last_const", d, 8'h99);

      // push with read while empty
      cycle("e_both", 1, 8'h7A, 1, 0, d);
      check("e_both_const", d, 8'h00);
      cycle("e_read", 0, 8'h00, 1, 0, d);
      check("e_read_const", d, 8'h7A);

      // wrap-around, count stays at most 1
      for (int i = 0; i < 40; i++) begin
         cycle("w_push", 1, 8'(8'h80 + i), 0, 0, d);
         cycle("w_stat", 0, 8'h00, 0, 1, d);
         cycle("w_read", 0, 8'h00, 1, 0, d);
      end

      // reset mid-operation
      for (int i = 0; i < 5; i++) cycle("r_push", 1, 8'(8'h20 + i), 0, 0, d);
      @(posedge clock);
      key_strobe = 1'b1; key_data = 8'hEE; read = 1'b1; address = 1'b0;
      #2 reset = 1'b0;
      #1;
      check("r_irq", {7'b0, irq}, 8'h00);
      check("r_data", data_out, 8'h00);
      address = 1'b1; #1;
      check("r_status", data_out, 8'h00);
      sb_q.delete();
      sb_ovf = 1'b0;
      @(negedge clock); #1;
      check("r_hold_irq", {7'b0, irq}, 8'h00);
      check("r_hold_status", data_out, 8'h00);
      @(posedge clock); #1;
      key_strobe = 1'b0; read = 1'b0; address = 1'b0;
      reset = 1'b1;
      cycle("r_push31", 1, 8'h31, 0, 0, d);
      cycle("r_read31", 0, 8'h00, 1, 0, d);
      check("r_read31_const", d, 8'h31);
      cycle("r_stat_end", 0, 8'h00, 0, 1, d);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
